// File: rtl/wb_ps2_defs.sv
// wb_ps2_defs: register map, status bit positions and receiver FSM encoding shared by wb_ps2.
// Pure declarations; no latency or flow control of its own.
package wb_ps2_defs;

  localparam logic PS2_DATA   = 1'b0;
  localparam logic PS2_STATUS = 1'b1;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_PERR = 3;
  localparam int ST_FERR = 4;
  localparam int ST_IE   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // PS/2 frames carry odd parity over data byte plus parity bit.
  function automatic logic odd_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, combinational head, push/pop take effect at the next edge.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/wb_ps2.sv
// wb_ps2: PS/2 receive-only host port buffering bytes in a FIFO behind a Wishbone slave.
// Ack one cycle after strobe; byte pushed one cycle after stop-bit fall; full FIFO drops bytes (OVF).
module wb_ps2 #(
  parameter int DEPTH   = 16,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [29:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic        irq_o
);
  import wb_ps2_defs::*;

  localparam int FCW = $clog2(FILTER + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  logic [1:0]     clk_sync, dat_sync, raw, filt;
  logic [FCW-1:0] fcnt [2];
  logic           fall;

  ps2_state_t     state, state_nxt;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par;
  logic [TCW-1:0] tcnt;
  logic           timeout, push_nxt, perr_set, ferr_set;
  logic           push_vld;
  logic [7:0]     push_dat;

  logic [7:0]     head;
  logic           full, empty, pop;
  logic           ovf, perr, ferr, ie;
  logic           req, wr_status;
  logic [31:0]    status_word, data_word;
  logic           unused_bits;

  assign unused_bits = ^{adr_i[29:1], sel_i[3:1], dat_i[31:6], dat_i[1:0]};

  // Lines idle high, so every conditioning stage resets to 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  assign raw = {dat_sync[1], clk_sync[1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt <= 2'b11;
      fcnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  // Strike on the same edge the filtered clock drops.
  assign fall    = filt[0] & ~raw[0] & (fcnt[0] == FCW'(FILTER - 1));
  assign timeout = (state != IDLE) && !fall && (tcnt == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_nxt  = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      ferr_set  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (!filt[1]) state_nxt = DATA;
        DATA:   if (bitcnt == 3'd7) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          perr_set  = ~odd_ok(shreg, par);
          ferr_set  = ~filt[1];
          push_nxt  = odd_ok(shreg, par) & filt[1];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bitcnt   <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tcnt     <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= push_nxt;
      if (push_nxt) push_dat <= shreg;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + TCW'(1);
      if (fall) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg  <= {filt[1], shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY: par <= filt[1];
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  assign req       = cyc_i & stb_i & ~ack_o;
  assign pop       = req & ~we_i & (adr_i[0] == PS2_DATA) & ~empty;
  assign wr_status = req & we_i & (adr_i[0] == PS2_STATUS) & sel_i[0];
  assign data_word = empty ? 32'd0 : {23'd0, 1'b1, head};

  always_comb begin
    status_word          = '0;
    status_word[ST_NE]   = ~empty;
    status_word[ST_FULL] = full;
    status_word[ST_OVF]  = ovf;
    status_word[ST_PERR] = perr;
    status_word[ST_FERR] = ferr;
    status_word[ST_IE]   = ie;
  end

  // Sticky flags: a set event in the same cycle as a W1C wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      irq_o <= 1'b0;
      ovf   <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ie    <= 1'b0;
    end else begin
      ack_o <= req;
      dat_o <= '0;
      if (req && !we_i) dat_o <= (adr_i[0] == PS2_STATUS) ? status_word : data_word;
      ovf   <= (push_vld & full & ~pop) | (ovf & ~(wr_status & dat_i[ST_OVF]));
      perr  <= perr_set | (perr & ~(wr_status & dat_i[ST_PERR]));
      ferr  <= ferr_set | (ferr & ~(wr_status & dat_i[ST_FERR]));
      if (wr_status) ie <= dat_i[ST_IE];
      irq_o <= ie & ~empty;
    end
  end

endmodule

// File: tb/tb_wb_ps2.sv
// tb_wb_ps2: directed and randomised PS/2 frames checked against a queue-based model.
// Bus accesses wait a bounded number of cycles for ack.
module tb_wb_ps2;
  localparam int DEPTH   = 16;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int H       = 20;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [29:0] adr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] dat_i = '0;
  logic        ack_o, irq_o;
  logic [31:0] dat_o;
  logic        ps2_clk = 1'b1, ps2_dat = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  logic m_ovf = 0, m_perr = 0, m_ferr = 0, m_ie = 0;

  always #5 clk_i = ~clk_i;

  wb_ps2 #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o),
    .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input logic w, input logic a, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] r);
    logic got;
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = {29'd0, a}; dat_i = d; sel_i = s;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk_i); #1;
      got = ack_o;
    end
    check("wb_ack", {31'd0, ack_o}, 32'd1);
    r = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  function automatic logic [31:0] m_status();
    return {26'd0, m_ie, m_ferr, m_perr, m_ovf, (mq.size() == DEPTH), (mq.size() != 0)};
  endfunction

  task automatic rd_data_chk(input string tag);
    logic [31:0] r, e;
    e = 32'd0;
    if (mq.size() > 0) e = {23'd0, 1'b1, mq.pop_front()};
    wb(1'b0, 1'b0, 32'd0, 4'hf, r);
    check(tag, r, e);
  endtask

  task automatic rd_status_chk(input string tag);
    logic [31:0] r;
    wb(1'b0, 1'b1, 32'd0, 4'hf, r);
    check(tag, r, m_status());
  endtask

  task automatic wr_status(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb(1'b1, 1'b1, d, s, r);
    if (s[0]) begin
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_perr = 1'b0;
      if (d[4]) m_ferr = 1'b0;
      m_ie = d[5];
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good frame, 1 bad parity, 2 bad stop bit
  task automatic ps2_frame(input logic [7:0] b, input int kind);
    logic p;
    p = ~^b;
    if (kind == 1) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(kind != 2);
    ps2_dat = 1'b1;
    tick(H);
    case (kind)
      0: if (mq.size() == DEPTH) m_ovf = 1'b1; else mq.push_back(b);
      1: m_perr = 1'b1;
      default: m_ferr = 1'b1;
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    int lows;
    logic [31:0] r;

    tick(3);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    rst_i = 1'b0;
    tick(2);
    rd_status_chk("rst_status");
    rd_data_chk("rst_data_empty");

    ps2_frame(8'h1C, 0);
    rd_status_chk("good_status");
    rd_data_chk("good_data");
    rd_data_chk("good_data_empty");

    ps2_frame(8'hF0, 1);
    rd_status_chk("perr_status");
    wr_status(32'h08, 4'h1);
    rd_status_chk("perr_cleared");

    wr_status(32'h3C, 4'h0);
    rd_status_chk("sel0_ignored");

    for (int i = 0; i <= 16; i++) ps2_frame(8'(i), 0);
    rd_status_chk("ovf_status");
    for (int i = 0; i <= 16; i++) rd_data_chk("ovf_drain");
    wr_status(32'h04, 4'h1);
    rd_status_chk("ovf_cleared");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    tick(TIMEOUT + 10);
    m_ferr = 1'b1;
    rd_status_chk("timeout_ferr");
    ps2_frame(8'h5A, 0);
    rd_data_chk("after_timeout");
    wr_status(32'h10, 4'h1);

    ps2_dat = 1'b0;
    tick(5);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(20);
    ps2_dat = 1'b1;
    tick(5);
    ps2_frame(8'h3C, 0);
    rd_status_chk("glitch_status");
    rd_data_chk("glitch_data");

    wr_status(32'h20, 4'h1);
    ps2_frame(8'h1C, 0);
    tick(2);
    check("irq_rise", {31'd0, irq_o}, 32'd1);
    lows = 0;
    fork
      ps2_frame(8'h2D, 0);
      begin
        repeat (11) @(negedge ps2_clk);
        repeat (9) @(posedge clk_i);
        rd_data_chk("simul_pop");
      end
      begin
        repeat (11) @(negedge ps2_clk);
        repeat (40) begin
          @(negedge clk_i);
          if (!irq_o) lows++;
        end
      end
    join
    check("irq_hold", 32'(lows), 32'd0);
    rd_status_chk("simul_status");
    rd_data_chk("simul_head");
    ps2_frame(8'h11, 0);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_dat = 1'b1;
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 30'd1;
    @(posedge clk_i); #1;
    check("pre_rst_ack", {31'd0, ack_o}, 32'd1);
    check("pre_rst_irq", {31'd0, irq_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_ack", {31'd0, ack_o}, 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    check("mid_rst_irq", {31'd0, irq_o}, 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    tick(3);
    rst_i = 1'b0;
    mq.delete();
    m_ovf = 0; m_perr = 0; m_ferr = 0; m_ie = 0;
    tick(2);
    rd_status_chk("post_rst_status");
    ps2_frame(8'hA5, 0);
    rd_data_chk("post_rst_data");

    for (int n = 0; n < 30; n++) begin
      int kind;
      kind = ($urandom_range(9) < 2) ? int'($urandom_range(2, 1)) : 0;
      ps2_frame(8'($urandom), kind);
      repeat ($urandom_range(2)) rd_data_chk("rand_data");
      if ($urandom_range(3) == 0) begin
        rd_status_chk("rand_status");
        wr_status({26'd0, 1'($urandom), 3'($urandom), 2'b00}, 4'($urandom));
      end
    end
    rd_status_chk("rand_final_status");
    while (mq.size() > 0) rd_data_chk("rand_drain");
    rd_data_chk("rand_drain_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
